adc_hyst_comp: RTL

Parametrised ADC threshold comparator for the SWIPT supply-monitor path. It sits between the ADC sample interface and the PLL/power control logic. It collects a block of ADC samples at a programmable period, averages them, and compares the average against a runtime-programmable hysteresis window. The result is a registered comparator bit plus a one-cycle decision strobe. It generalises the fixed 12-bit, fixed-midscale comparator with variable width, averaging depth, sample period, a handshake, and hysteresis.

---
 rtl/adc_hyst_comp.sv | 136 +++++++++++++
 1 files changed

// File: rtl/adc_hyst_comp.sv
// adc_hyst_comp: block-averaging ADC comparator with a programmable hysteresis window.
// Waits PERIOD cycles, then accepts 2^AVG_LOG2 samples through a valid/req handshake, then
// compares the truncated average against thr_hi/thr_lo. Each decision produces a one-cycle
// comp_valid strobe.
// Optional feature: define ADC_COMP_DEGLITCH_EN to require two consecutive decisions that
// agree before comp_out changes.
module adc_hyst_comp #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned PERIOD   = 200
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             swipt_alive,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_data,
  output logic             sample_req,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic             comp_out,
  output logic             comp_valid,
  output logic [WIDTH-1:0] avg_out
);

  localparam int unsigned AccW  = WIDTH + AVG_LOG2;
  localparam int unsigned CntW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned SCntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0]  CntLoad    = CntW'(PERIOD - 1);
  localparam logic [SCntW-1:0] LastSample = SCntW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccum, StDecide} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [AccW-1:0]    acc_q;
  logic [SCntW-1:0]   scnt_q;

  logic               clear;
  logic               take;
  logic [WIDTH-1:0]   avg;
  logic               has_req;
  logic               req_val;

  assign clear = !nrst || !swipt_alive;
  assign take  = adc_valid && sample_req;
  // Truncating divide by 2^AVG_LOG2.
  assign avg   = acc_q[AVG_LOG2 +: WIDTH];

  // Decision request: thr_hi is tested first so an inverted window still resolves.
  always_comb begin
    has_req = 1'b0;
    req_val = 1'b0;
    if (avg > thr_hi) begin
      has_req = 1'b1;
      req_val = 1'b0;
    end else if (avg < thr_lo) begin
      has_req = 1'b1;
      req_val = 1'b1;
    end
  end

`ifdef ADC_COMP_DEGLITCH_EN
  logic pend_q;
  logic pend_val_q;
`endif

  // Sequencer with registered outputs; clear overrides every state.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      scnt_q     <= '0;
      sample_req <= 1'b0;
      comp_out   <= 1'b0;
      comp_valid <= 1'b0;
      avg_out    <= '0;
`ifdef ADC_COMP_DEGLITCH_EN
      pend_q     <= 1'b0;
      pend_val_q <= 1'b0;
`endif
    end else begin
      comp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q <= StWait;
          cnt_q   <= CntLoad;
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q    <= StAccum;
            acc_q      <= '0;
            scnt_q     <= '0;
            sample_req <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StAccum: begin
          if (take) begin
            acc_q  <= acc_q + AccW'(adc_data);
            scnt_q <= scnt_q + SCntW'(1);
            if (scnt_q == LastSample) begin
              sample_req <= 1'b0;
              state_q    <= StDecide;
            end
          end
        end
        StDecide: begin
          avg_out    <= avg;
          comp_valid <= 1'b1;
`ifdef ADC_COMP_DEGLITCH_EN
          // Only a repeated, differing request is allowed to move comp_out.
          if (!has_req || (req_val == comp_out)) begin
            pend_q <= 1'b0;
          end else if (pend_q && (pend_val_q == req_val)) begin
            comp_out <= req_val;
            pend_q   <= 1'b0;
          end else begin
            pend_q     <= 1'b1;
            pend_val_q <= req_val;
          end
`else
          if (has_req) begin
            comp_out <= req_val;
          end
`endif
          state_q <= StWait;
          cnt_q   <= CntLoad;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
